// File: rtl/matmul_pkg.sv
// Shared types, default sizing and helpers for the matmul job sequencer.
//   state_e       : sequencer FSM states
//   len_w/idx_w   : width helpers for 1..MAX counts and 0..MAX-1 indices
//   cfg_in_range  : job-configuration range check (1..max)
package matmul_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_WEIGHT_WIDTH = 8;
    localparam int unsigned DEF_OUTPUT_WIDTH = 8;
    localparam int unsigned DEF_MAC_NUM      = 8;
    localparam int unsigned DEF_MAX_K        = 16;
    localparam int unsigned DEF_MAX_COLS     = 16;
    localparam int unsigned DEF_ADDR_W       = 8;
    localparam int unsigned DEF_TIMEOUT      = 64;

    // Width able to hold the value max_v itself (a length).
    function automatic int unsigned len_w(input int unsigned max_v);
        return $clog2(max_v) + 1;
    endfunction

    // Width able to hold 0..max_v-1 (an index), never below 1.
    function automatic int unsigned idx_w(input int unsigned max_v);
        return (max_v > 1) ? $clog2(max_v) : 1;
    endfunction

    // A length is legal when it is 1..max_v.
    function automatic logic cfg_in_range(input int unsigned val, input int unsigned max_v);
        return (val != 0) && (val <= max_v);
    endfunction

    localparam int unsigned K_W       = len_w(DEF_MAX_K);
    localparam int unsigned COL_W     = len_w(DEF_MAX_COLS);
    localparam int unsigned COL_IDX_W = idx_w(DEF_MAX_COLS);
    localparam int unsigned LANE_W    = DEF_MAC_NUM * DEF_DATA_WIDTH;
    localparam int unsigned RES_W     = DEF_MAC_NUM * DEF_OUTPUT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STREAM    = 3'd1,
        S_DRAIN     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WRITE     = 3'd4
    } state_e;

endpackage

// File: rtl/matmul_addr_gen.sv
// Beat / column / linear operand-address counters for one job.
//   i_load              : latch lengths and clear counters (job start)
//   i_k_len, i_n_cols   : beats per column, columns per job
//   i_step              : advance one beat (holds on the last beat)
//   i_next_col          : move to the next column, address continues linearly
//   o_addr, o_col       : linear address col*K+beat, current column index
//   o_last_beat/o_last_col : terminal-count flags
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int unsigned MAX_K    = DEF_MAX_K,
    parameter int unsigned MAX_COLS = DEF_MAX_COLS,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          i_load,
    input  logic [len_w(MAX_K)-1:0]       i_k_len,
    input  logic [len_w(MAX_COLS)-1:0]    i_n_cols,
    input  logic                          i_step,
    input  logic                          i_next_col,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [idx_w(MAX_COLS)-1:0]    o_col,
    output logic                          o_last_beat,
    output logic                          o_last_col
);

    localparam int unsigned KL_W = len_w(MAX_K);
    localparam int unsigned NC_W = len_w(MAX_COLS);
    localparam int unsigned CI_W = idx_w(MAX_COLS);

    logic [KL_W-1:0]   r_k_len;
    logic [NC_W-1:0]   r_n_cols;
    logic [KL_W-1:0]   r_beat;
    logic [NC_W-1:0]   r_col;
    logic [ADDR_W-1:0] r_addr;

    assign o_last_beat = (r_beat == KL_W'(r_k_len - KL_W'(1)));
    assign o_last_col  = (r_col == NC_W'(r_n_cols - NC_W'(1)));
    assign o_addr      = r_addr;
    assign o_col       = CI_W'(r_col);

    // The address stays on the last beat so it never passes K*N-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_k_len  <= '0;
            r_n_cols <= '0;
            r_beat   <= '0;
            r_col    <= '0;
            r_addr   <= '0;
        end else if (i_load) begin
            r_k_len  <= i_k_len;
            r_n_cols <= i_n_cols;
            r_beat   <= '0;
            r_col    <= '0;
            r_addr   <= '0;
        end else if (i_next_col) begin
            r_beat   <= '0;
            r_col    <= r_col + NC_W'(1);
            r_addr   <= r_addr + ADDR_W'(1);
        end else if (i_step && !o_last_beat) begin
            r_beat   <= r_beat + KL_W'(1);
            r_addr   <= r_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Job controller feeding Matrix_Multiplier column by column.
//   clk_i/rst_i           : clock, async active-high reset
//   start_i, k_len_i, n_cols_i : job request and shape
//   busy_o, done_o, err_o : job status (done/err are one-cycle pulses)
//   act_*/w_*             : operand buffer read ports (1-cycle latency)
//   mm_*                  : multiplier stream and response
//   res_*                 : result buffer write port, one write per column
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int unsigned WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter  int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter  int unsigned MAC_NUM      = DEF_MAC_NUM,
    parameter  int unsigned MAX_K        = DEF_MAX_K,
    parameter  int unsigned MAX_COLS     = DEF_MAX_COLS,
    parameter  int unsigned ADDR_W       = DEF_ADDR_W,
    parameter  int unsigned TIMEOUT      = DEF_TIMEOUT,
    localparam int unsigned KL_W         = len_w(MAX_K),
    localparam int unsigned NC_W         = len_w(MAX_COLS),
    localparam int unsigned CI_W         = idx_w(MAX_COLS),
    localparam int unsigned DIN_W        = MAC_NUM * DATA_WIDTH,
    localparam int unsigned MM_W         = MAC_NUM * OUTPUT_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [KL_W-1:0]         k_len_i,
    input  logic [NC_W-1:0]         n_cols_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [ADDR_W-1:0]       act_raddr_o,
    input  logic [DIN_W-1:0]        act_rdata_i,
    output logic [ADDR_W-1:0]       w_raddr_o,
    input  logic [WEIGHT_WIDTH-1:0] w_rdata_i,
    output logic                    mm_en_o,
    output logic                    mm_valid_o,
    output logic [DIN_W-1:0]        mm_din_o,
    output logic [WEIGHT_WIDTH-1:0] mm_win_o,
    input  logic                    mm_done_i,
    input  logic [MM_W-1:0]         mm_matmul_i,
    output logic                    res_we_o,
    output logic [CI_W-1:0]         res_waddr_o,
    output logic [MM_W-1:0]         res_wdata_o
);

    localparam int unsigned TO_W = len_w(TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_err_nxt;
    logic              w_cfg_ok;
    logic              w_load;
    logic              w_next_col;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_addr;
    logic [CI_W-1:0]   w_col;
    logic              w_last_beat;
    logic              w_last_col;
    logic              r_issue;
    logic              r_issue_last;
    logic              r_err;
    logic [TO_W-1:0]   r_wait_cnt;
    logic [MM_W-1:0]   r_result;

    assign w_cfg_ok   = cfg_in_range(32'(k_len_i), MAX_K) && cfg_in_range(32'(n_cols_i), MAX_COLS);
    assign w_load     = (r_state == S_IDLE) && start_i && w_cfg_ok;
    assign w_next_col = (r_state == S_WRITE) && !w_last_col;
    assign w_timeout  = (r_wait_cnt == TO_W'(TIMEOUT - 1));

    matmul_addr_gen #(
        .MAX_K    (MAX_K),
        .MAX_COLS (MAX_COLS),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_load      (w_load),
        .i_k_len     (k_len_i),
        .i_n_cols    (n_cols_i),
        .i_step      (r_state == S_STREAM),
        .i_next_col  (w_next_col),
        .o_addr      (w_addr),
        .o_col       (w_col),
        .o_last_beat (w_last_beat),
        .o_last_col  (w_last_col)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and error-pulse request.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_cfg_ok) w_state_nxt = S_STREAM;
                    else          w_err_nxt   = 1'b1;
                end
            end
            S_STREAM:    if (w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN:     w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (mm_done_i) begin
                    w_state_nxt = S_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WRITE:     w_state_nxt = w_last_col ? S_IDLE : S_STREAM;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs; the read address reads as 0 whenever the block is idle.
    always_comb begin
        busy_o      = (r_state != S_IDLE);
        act_raddr_o = '0;
        w_raddr_o   = '0;
        res_we_o    = 1'b0;
        res_waddr_o = '0;
        res_wdata_o = '0;
        done_o      = 1'b0;
        err_o       = r_err;
        mm_en_o     = r_issue;
        mm_valid_o  = r_issue_last;
        mm_din_o    = r_issue ? act_rdata_i : '0;
        mm_win_o    = r_issue ? w_rdata_i   : '0;
        if (r_state != S_IDLE) begin
            act_raddr_o = w_addr;
            w_raddr_o   = w_addr;
        end
        if (r_state == S_WRITE) begin
            res_we_o    = 1'b1;
            res_waddr_o = w_col;
            res_wdata_o = r_result;
            done_o      = w_last_col;
        end
    end

    // Issue flag trails the address by one cycle to line up with read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_issue      <= 1'b0;
            r_issue_last <= 1'b0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
            r_result     <= '0;
        end else begin
            r_issue      <= (r_state == S_STREAM);
            r_issue_last <= (r_state == S_STREAM) && w_last_beat;
            r_err        <= w_err_nxt;
            if (r_state == S_WAIT_DONE) r_wait_cnt <= r_wait_cnt + TO_W'(1);
            else                        r_wait_cnt <= '0;
            if ((r_state == S_WAIT_DONE) && mm_done_i) r_result <= mm_matmul_i;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: operand memories, a multiplier responder that records
// the result it returns, and a monitor logging beats/writes/pulses. Expected
// streams come from the memories indexed linearly per job.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int unsigned TMO  = 64;
    localparam int unsigned MAXK = 16;
    localparam int unsigned MAXC = 16;
    localparam int          NREC = 4096;

    logic                  clk_i;
    logic                  rst_i;
    logic                  start_i;
    logic [K_W-1:0]        k_len_i;
    logic [COL_W-1:0]      n_cols_i;
    logic                  busy_o, done_o, err_o;
    logic [DEF_ADDR_W-1:0] act_raddr_o, w_raddr_o;
    logic [LANE_W-1:0]     act_rdata_i;
    logic [7:0]            w_rdata_i;
    logic                  mm_en_o, mm_valid_o;
    logic [LANE_W-1:0]     mm_din_o;
    logic [7:0]            mm_win_o;
    logic                  mm_done_i;
    logic [RES_W-1:0]      mm_matmul_i;
    logic                  res_we_o;
    logic [COL_IDX_W-1:0]  res_waddr_o;
    logic [RES_W-1:0]      res_wdata_o;

    matmul_sequencer #(
        .MAX_K    (MAXK),
        .MAX_COLS (MAXC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .n_cols_i    (n_cols_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .act_raddr_o (act_raddr_o),
        .act_rdata_i (act_rdata_i),
        .w_raddr_o   (w_raddr_o),
        .w_rdata_i   (w_rdata_i),
        .mm_en_o     (mm_en_o),
        .mm_valid_o  (mm_valid_o),
        .mm_din_o    (mm_din_o),
        .mm_win_o    (mm_win_o),
        .mm_done_i   (mm_done_i),
        .mm_matmul_i (mm_matmul_i),
        .res_we_o    (res_we_o),
        .res_waddr_o (res_waddr_o),
        .res_wdata_o (res_wdata_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Operand buffers with one-cycle read latency.
    logic [LANE_W-1:0] act_mem [256];
    logic [7:0]        w_mem   [256];
    always @(posedge clk_i) begin
        act_rdata_i <= act_mem[act_raddr_o];
        w_rdata_i   <= w_mem[w_raddr_o];
    end

    // Multiplier responder: answers resp_delay cycles after the last beat.
    bit               resp_on    = 1'b1;
    bit               spur_req   = 1'b0;
    int               resp_delay = 3;
    int               rcnt       = 0;
    int               n_exp      = 0;
    logic [RES_W-1:0] exp_res [NREC];
    always @(negedge clk_i) begin
        mm_matmul_i = {$urandom, $urandom};
        mm_done_i   = 1'b0;
        if (rst_i) begin
            rcnt = 0;
        end else begin
            if (rcnt != 0) begin
                rcnt = rcnt - 1;
                if (rcnt == 0) begin
                    mm_done_i      = 1'b1;
                    exp_res[n_exp] = mm_matmul_i;
                    n_exp          = n_exp + 1;
                end
            end else if (spur_req && mm_en_o && !mm_valid_o) begin
                mm_done_i = 1'b1;
            end
            if (resp_on && mm_en_o && mm_valid_o) rcnt = resp_delay;
        end
    end

    // Monitor.
    int                cyc = 0, n_busy = 0, n_beats = 0, n_writes = 0;
    int                n_done = 0, n_err = 0, n_leak = 0, valid_cyc = 0, err_cyc = 0;
    logic [LANE_W-1:0] beat_din [NREC];
    logic [7:0]        beat_win [NREC];
    logic              beat_vld [NREC];
    logic [COL_IDX_W-1:0] wr_addr [NREC];
    logic [RES_W-1:0]  wr_data [NREC];
    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (busy_o) n_busy = n_busy + 1;
        if (mm_en_o) begin
            beat_din[n_beats] = mm_din_o;
            beat_win[n_beats] = mm_win_o;
            beat_vld[n_beats] = mm_valid_o;
            n_beats = n_beats + 1;
            if (mm_valid_o) valid_cyc = cyc;
        end else if ((mm_din_o != '0) || (mm_win_o != '0) || mm_valid_o) begin
            n_leak = n_leak + 1;
        end
        if (res_we_o) begin
            wr_addr[n_writes] = res_waddr_o;
            wr_data[n_writes] = res_wdata_o;
            n_writes = n_writes + 1;
        end
        if (done_o) n_done = n_done + 1;
        if (err_o) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
    end

    int n_errs   = 0;
    int n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errs = n_errs + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = {$urandom, $urandom};
            w_mem[i]   = 8'($urandom);
        end
    endtask

    task automatic fill_nominal();
        logic [7:0] a, b;
        for (int i = 0; i < 256; i++) begin
            a = 8'(2 * (i % 4) + 1);
            b = 8'(2 * (i % 4) + 2);
            act_mem[i] = {4{a, b}};
            w_mem[i]   = 8'((i % 4) + 1);
        end
    endtask

    task automatic pulse_start(input int k, input int n);
        @(negedge clk_i);
        k_len_i  = K_W'(k);
        n_cols_i = COL_W'(n);
        start_i  = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
    endtask

    // One full job; expectations come from the memories and the responder log.
    task automatic run_job(input string tag, input int k, input int n, input int dly,
                           input bit spur, input bit restart);
        int b0, w0, r0, d0, e0, budget, nb, nw;
        b0 = n_beats; w0 = n_writes; r0 = n_exp; d0 = n_done; e0 = n_err;
        resp_delay = dly;
        spur_req   = spur;
        resp_on    = 1'b1;
        pulse_start(k, n);
        if (restart) begin
            repeat (2) @(negedge clk_i);
            chk({tag, "_busy"}, 64'(busy_o), 64'd1);
            k_len_i  = K_W'(1);
            n_cols_i = COL_W'(1);
            start_i  = 1'b1;
            @(negedge clk_i);
            start_i  = 1'b0;
        end
        budget = 0;
        while (n_done == d0 && n_err == e0 && budget < 4000) begin
            @(negedge clk_i);
            budget++;
        end
        repeat (3) @(negedge clk_i);
        spur_req = 1'b0;
        chk({tag, "_finished"}, 64'(budget < 4000), 64'd1);
        chk({tag, "_done_cnt"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_err_cnt"}, 64'(n_err - e0), 64'd0);
        chk({tag, "_beats"}, 64'(n_beats - b0), 64'(k * n));
        chk({tag, "_writes"}, 64'(n_writes - w0), 64'(n));
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
        nb = (n_beats - b0 < k * n) ? (n_beats - b0) : (k * n);
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s_din%0d", tag, i), 64'(beat_din[b0 + i]), 64'(act_mem[i]));
            chk($sformatf("%s_win%0d", tag, i), 64'(beat_win[b0 + i]), 64'(w_mem[i]));
            chk($sformatf("%s_vld%0d", tag, i), 64'(beat_vld[b0 + i]), 64'((i % k) == k - 1));
        end
        nw = (n_writes - w0 < n) ? (n_writes - w0) : n;
        for (int j = 0; j < nw; j++) begin
            chk($sformatf("%s_waddr%0d", tag, j), 64'(wr_addr[w0 + j]), 64'(j));
            if (r0 + j < n_exp)
                chk($sformatf("%s_wdata%0d", tag, j), 64'(wr_data[w0 + j]), 64'(exp_res[r0 + j]));
        end
    endtask

    task automatic cfg_err(input string tag, input int k, input int n);
        int b0, e0, bz0, d0;
        b0 = n_beats; e0 = n_err; bz0 = n_busy; d0 = n_done;
        pulse_start(k, n);
        repeat (4) @(negedge clk_i);
        chk({tag, "_err"}, 64'(n_err - e0), 64'd1);
        chk({tag, "_busy"}, 64'(n_busy - bz0), 64'd0);
        chk({tag, "_no_en"}, 64'(n_beats - b0), 64'd0);
        chk({tag, "_no_done"}, 64'(n_done - d0), 64'd0);
    endtask

    initial begin
        int b0, w0, d0, e0, budget;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        k_len_i  = '0;
        n_cols_i = '0;
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = '0;
            w_mem[i]   = '0;
        end
        repeat (3) @(negedge clk_i);
        chk("rst_flags", 64'({busy_o, done_o, err_o, mm_en_o, mm_valid_o, res_we_o}), 64'd0);
        chk("rst_raddr", 64'({act_raddr_o, w_raddr_o}), 64'd0);
        chk("rst_mm_data", 64'(mm_din_o) | 64'(mm_win_o), 64'd0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Nominal K=4, N=2, response 3 cycles after valid.
        fill_nominal();
        run_job("nom", 4, 2, 3, 1'b0, 1'b0);

        // Illegal shapes.
        cfg_err("cfg_k0", 0, 2);
        cfg_err("cfg_n17", 4, int'(MAXC) + 1);
        cfg_err("cfg_k17", int'(MAXK) + 1, 1);
        cfg_err("cfg_n0", 3, 0);

        // Timeout: multiplier never answers.
        fill_random();
        b0 = n_beats; w0 = n_writes; d0 = n_done; e0 = n_err;
        resp_on = 1'b0;
        pulse_start(2, 1);
        budget = 0;
        while (n_err == e0 && budget < 500) begin
            @(negedge clk_i);
            budget++;
        end
        repeat (2) @(negedge clk_i);
        chk("tmo_finished", 64'(budget < 500), 64'd1);
        chk("tmo_err_cnt", 64'(n_err - e0), 64'd1);
        chk("tmo_latency", 64'(err_cyc - valid_cyc), 64'(TMO + 1));
        chk("tmo_no_write", 64'(n_writes - w0), 64'd0);
        chk("tmo_no_done", 64'(n_done - d0), 64'd0);
        chk("tmo_beats", 64'(n_beats - b0), 64'd2);
        chk("tmo_idle", 64'(busy_o), 64'd0);
        resp_on = 1'b1;

        // Start while busy is ignored.
        fill_random();
        run_job("busy_start", 6, 3, 2, 1'b0, 1'b0 | 1'b1);

        // Spurious done during streaming.
        fill_random();
        run_job("spur", 5, 3, 4, 1'b1, 1'b0);

        // Reset during the 3rd beat of column 1.
        fill_random();
        b0 = n_beats; w0 = n_writes; d0 = n_done;
        resp_delay = 2;
        pulse_start(4, 2);
        budget = 0;
        while (n_beats - b0 < 6 && budget < 200) begin
            @(negedge clk_i);
            #1;
            budget++;
        end
        chk("mrst_reached", 64'(budget < 200), 64'd1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mrst_flags", 64'({busy_o, done_o, err_o, mm_en_o, mm_valid_o, res_we_o}), 64'd0);
        chk("mrst_raddr", 64'({act_raddr_o, w_raddr_o}), 64'd0);
        chk("mrst_din", 64'(mm_din_o), 64'd0);
        chk("mrst_res", 64'(res_wdata_o) | 64'(res_waddr_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        chk("mrst_writes", 64'(n_writes - w0), 64'd1);
        chk("mrst_no_done", 64'(n_done - d0), 64'd0);
        fill_random();
        run_job("after_rst", 1, 1, 1, 1'b0, 1'b0);

        // Randomized jobs.
        for (int t = 0; t < 10; t++) begin
            fill_random();
            run_job($sformatf("rnd%0d", t), int'($urandom_range(1, MAXK)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
                    1'($urandom_range(0, 1)), 1'b0);
        end
        run_job("maxk", int'(MAXK), 2, 1, 1'b0, 1'b0);

        chk("no_leak", 64'(n_leak), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
